// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers conditional-branch resolutions from execute and
// replays them to the BHT one per cycle, in resolution order.
// Optional macro BHT_UPD_HAZARD_GAP_EN: inserts a one-cycle bubble when the
// head entry targets the same BHT row as the update issued the cycle before,
// which leaves a read-modify-write gap for a synchronous BHT RAM.
module bht_update_queue #(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IDX_LSB  = 1,
  parameter int unsigned IDX_BITS = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_bp_i,
  input  logic                     debug_mode_i,
  input  logic                     res_valid_i,
  input  logic [VLEN-1:0]          res_pc_i,
  input  logic                     res_is_cond_i,
  input  logic                     res_taken_i,
  output logic                     upd_valid_o,
  output logic [VLEN-1:0]          upd_pc_o,
  output logic                     upd_taken_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [7:0]               drop_cnt_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  // Elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bht_update_queue: DEPTH must be a power of two >= 2");
  end
  if (IDX_LSB + IDX_BITS > VLEN) begin : g_bad_idx
    $error("bht_update_queue: BHT index field exceeds VLEN");
  end

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wptr, rptr;
  logic [PW:0]     occ;
  logic [7:0]      drop_cnt;
  logic            not_empty, full, enq_elig, enq, deq, drop, gap_stall;

  assign head      = mem[rptr];
  assign not_empty = (occ != '0);
  assign full      = (occ == (PW+1)'(DEPTH));
  assign enq_elig  = res_valid_i & res_is_cond_i & ~debug_mode_i & ~flush_bp_i;
  // Flush kills the issue slot so nothing stale reaches the BHT
  assign deq       = not_empty & ~gap_stall & ~flush_bp_i;
  // A full queue still accepts when the head leaves in the same cycle
  assign enq       = enq_elig & (~full | deq);
  assign drop      = enq_elig & full & ~deq;

  assign upd_valid_o = deq;
  // Storage is not reset, so gate the head while the queue is empty
  assign upd_pc_o    = not_empty ? head.pc    : '0;
  assign upd_taken_o = not_empty ? head.taken : 1'b0;
  assign occupancy_o = occ;
  assign drop_cnt_o  = drop_cnt;

`ifdef BHT_UPD_HAZARD_GAP_EN
  logic [IDX_BITS-1:0] head_idx, last_idx;
  logic                last_vld;

  assign head_idx  = head.pc[IDX_LSB +: IDX_BITS];
  assign gap_stall = not_empty & last_vld & (head_idx == last_idx);

  // Remember the row touched by the update issued this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_vld <= 1'b0;
      last_idx <= '0;
    end else if (flush_bp_i) begin
      last_vld <= 1'b0;
    end else begin
      last_vld <= deq;
      if (deq) last_idx <= head_idx;
    end
  end
`else
  assign gap_stall = 1'b0;
`endif

  // FIFO payload write; contents are only meaningful below occupancy
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= '{pc: res_pc_i, taken: res_taken_i};
  end

  // Pointers and occupancy; flush empties the queue and rewinds both pointers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (flush_bp_i) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      case ({enq, deq})
        2'b10:   occ <= occ + (PW+1)'(1);
        2'b01:   occ <= occ - (PW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Saturating count of resolutions lost to a full queue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                         drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
  end
endmodule
